// File: rtl/fifo_pkg.sv
// Shared constants, cell load-select encoding and width helper for the io881 FIFOs.
package fifo_pkg;

    localparam int FIFO_WIDTH_DEFAULT = 8;
    localparam int FIFO_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        SEL_HOLD  = 2'd0,
        SEL_SHIFT = 2'd1,
        SEL_LOAD  = 2'd2
    } cell_sel_e;

    // Width needed to represent 0..depth inclusive.
    function automatic int cw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_chain_cell.sv
// One shift-register FIFO storage cell: data word plus occupancy flag.
module fifo_chain_cell
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  cell_sel_e        sel,
    input  logic [WIDTH-1:0] next_data,
    input  logic             next_used,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] data,
    output logic             used
);

    // Flush only drops occupancy; stale data is harmless once unused.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data <= '0;
            used <= 1'b0;
        end else if (flush) begin
            used <= 1'b0;
        end else begin
            case (sel)
                SEL_SHIFT: begin
                    data <= next_data;
                    used <= next_used;
                end
                SEL_LOAD: begin
                    data <= d_in;
                    used <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_chain.sv
// Parametrised shift-register FIFO built from DEPTH fifo_chain_cell instances.
// Optional fill-level port enabled by defining FIFO_CHAIN_COUNT_EN.
module fifo_chain
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEFAULT,
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        d_in,
    input  logic                    d_in_strobe,
    output logic [WIDTH-1:0]        q_out,
    input  logic                    q_out_strobe,
    output logic                    empty,
    output logic                    full,
    output logic                    overflow,
`ifdef FIFO_CHAIN_COUNT_EN
    output logic                    underflow,
    output logic [cw(DEPTH)-1:0]    count
`else
    output logic                    underflow
`endif
);

    logic [WIDTH-1:0] cell_data [DEPTH];
    logic [DEPTH-1:0] used;
    logic             wr_req;
    logic             rd_req;
    logic             do_rd;
    logic             do_wr;

    assign empty = ~used[0];
    assign full  = used[DEPTH-1];
    assign q_out = cell_data[0];

    assign wr_req = d_in_strobe & ~flush;
    assign rd_req = q_out_strobe & ~flush;
    assign do_rd  = rd_req & used[0];
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign do_wr  = wr_req & (~used[DEPTH-1] | do_rd);

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        cell_sel_e        sel;
        logic [WIDTH-1:0] next_data;
        logic             next_used;
        logic             is_top;
        logic             is_slot;

        if (i == DEPTH - 1) begin : g_last
            assign next_data = '0;
            assign next_used = 1'b0;
            assign is_top    = used[i];
        end else begin : g_mid
            assign next_data = cell_data[i+1];
            assign next_used = used[i+1];
            assign is_top    = used[i] & ~used[i+1];
        end

        if (i == 0) begin : g_first
            assign is_slot = ~used[0];
        end else begin : g_rest
            assign is_slot = ~used[i] & used[i-1];
        end

        // On read+write the new word lands in the old highest-used cell after the shift.
        always_comb begin
            sel = SEL_HOLD;
            if (do_rd) begin
                sel = (do_wr && is_top) ? SEL_LOAD : SEL_SHIFT;
            end else if (do_wr && is_slot) begin
                sel = SEL_LOAD;
            end
        end

        fifo_chain_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .clk       (clk),
            .reset_n   (reset_n),
            .flush     (flush),
            .sel       (sel),
            .next_data (next_data),
            .next_used (next_used),
            .d_in      (d_in),
            .data      (cell_data[i]),
            .used      (used[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_req && !do_wr) overflow  <= 1'b1;
            if (rd_req && !do_rd) underflow <= 1'b1;
        end
    end

`ifdef FIFO_CHAIN_COUNT_EN
    localparam int CW = cw(DEPTH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (do_wr && !do_rd) begin
            count <= count + CW'(1);
        end else if (do_rd && !do_wr) begin
            count <= count - CW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_chain.sv
// Self-checking bench for fifo_chain: directed steps plus random traffic against a queue model.
module tb_fifo_chain;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             reset_n;
    logic             flush;
    logic [WIDTH-1:0] d_in;
    logic             d_in_strobe;
    logic [WIDTH-1:0] q_out;
    logic             q_out_strobe;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;
`ifdef FIFO_CHAIN_COUNT_EN
    logic [2:0]       count;
`endif

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] mq[$];
    logic             m_ovf;
    logic             m_unf;

    fifo_chain #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .d_in         (d_in),
        .d_in_strobe  (d_in_strobe),
        .q_out        (q_out),
        .q_out_strobe (q_out_strobe),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow),
`ifdef FIFO_CHAIN_COUNT_EN
        .underflow    (underflow),
        .count        (count)
`else
        .underflow    (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
        if (mq.size() != 0) chk({tag, ".q"}, 32'(q_out), 32'(mq[0]));
`ifdef FIFO_CHAIN_COUNT_EN
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
`endif
    endtask

    // Apply one cycle of strobes, update the queue model at the edge, then check.
    task automatic step(input logic wr, input logic [WIDTH-1:0] wd, input logic rd,
                        input logic fl, input string tag);
        bit popped;
        @(negedge clk);
        d_in = wd;
        d_in_strobe = wr;
        q_out_strobe = rd;
        flush = fl;
        @(posedge clk);
        if (fl) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            popped = 1'b0;
            if (rd) begin
                if (mq.size() == 0) m_unf = 1'b1;
                else begin
                    void'(mq.pop_front());
                    popped = 1'b1;
                end
            end
            if (wr) begin
                if (mq.size() < DEPTH) mq.push_back(wd);
                else m_ovf = 1'b1;
            end
            if (popped && wr && mq.size() > DEPTH) m_ovf = 1'b1;
        end
        #1;
        check_all(tag);
        @(negedge clk);
        d_in_strobe = 1'b0;
        q_out_strobe = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        flush = 1'b0;
        d_in = '0;
        d_in_strobe = 1'b0;
        q_out_strobe = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        #12;
        chk("rst.q", 32'(q_out), 32'h0);
        check_all("rst");
        @(negedge clk);
        reset_n = 1'b1;

        step(1, 8'hAA, 0, 0, "wr_aa");
        step(0, 8'h00, 1, 0, "rd_aa");
        step(0, 8'h00, 0, 1, "flush0");

        step(1, 8'h11, 0, 0, "fill1");
        step(1, 8'h22, 0, 0, "fill2");
        step(1, 8'h33, 0, 0, "fill3");
        step(1, 8'h44, 0, 0, "fill4");
        step(1, 8'h55, 0, 0, "ovf");
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, "drain");
        step(0, 8'h00, 0, 1, "flush1");

        step(1, 8'h11, 0, 0, "rw_a");
        step(1, 8'h22, 0, 0, "rw_b");
        step(1, 8'h77, 1, 0, "rw_mid");
        chk("rw_mid.q22", 32'(q_out), 32'h22);
        step(1, 8'h88, 0, 0, "rw_c");
        step(1, 8'h99, 0, 0, "rw_d");
        step(1, 8'h66, 1, 0, "rw_full");
        chk("rw_full.full", 32'(full), 32'h1);
        chk("rw_full.ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, "rw_drain");
        step(0, 8'h00, 1, 0, "unf");
        step(1, 8'h5A, 1, 0, "rw_empty");
        chk("rw_empty.q", 32'(q_out), 32'h5A);
        step(0, 8'h00, 0, 1, "flush2");

        step(1, 8'h01, 0, 0, "f3a");
        step(1, 8'h02, 0, 0, "f3b");
        step(1, 8'h03, 0, 0, "f3c");
        step(1, 8'h99, 0, 1, "flush_wr");
        chk("flush_wr.empty", 32'(empty), 32'h1);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 29) == 0), "rand");
        end

        step(0, 8'h00, 0, 1, "flush3");
        step(1, 8'hC1, 0, 0, "ar_a");
        step(1, 8'hC2, 0, 0, "ar_b");
        step(1, 8'hC3, 0, 0, "ar_c");
        step(0, 8'h00, 1, 0, "ar_u");
        step(0, 8'h00, 1, 0, "ar_u2");
        step(0, 8'h00, 1, 0, "ar_u3");
        step(0, 8'h00, 1, 0, "ar_unf");
        step(1, 8'hD1, 0, 0, "ar_d");
        step(1, 8'hD2, 0, 0, "ar_e");
        step(1, 8'hD3, 0, 0, "ar_f");
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        #1;
        chk("arst.q", 32'(q_out), 32'h0);
        check_all("arst");
        @(negedge clk);
        reset_n = 1'b1;
        step(1, 8'hE7, 0, 0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
